// File: rtl/token_scanner_pkg.sv
// Shared types for the token scanner: token kinds, FSM states, character classes
// and the ASCII classifier used by the scanner FSM.
package tok_pkg;

    typedef enum logic [1:0] {
        TOK_IDENT  = 2'd0,
        TOK_NUMBER = 2'd1,
        TOK_ERROR  = 2'd2
    } tok_type_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_IDENT = 3'd1,
        S_NUM   = 3'd2,
        S_ZERO  = 3'd3,
        S_HXP   = 3'd4,
        S_HEX   = 3'd5,
        S_BAD   = 3'd6
    } state_e;

    // '0', x/X and a-f/A-F get their own classes because the number states need them.
    typedef enum logic [2:0] {
        C_DELIM  = 3'd0,
        C_ZERO   = 3'd1,
        C_DIGIT  = 3'd2,
        C_HEXL   = 3'd3,
        C_XL     = 3'd4,
        C_LETTER = 3'd5
    } cls_e;

    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_9      = 8'h39;
    localparam logic [7:0] ASCII_UA     = 8'h41;
    localparam logic [7:0] ASCII_UF     = 8'h46;
    localparam logic [7:0] ASCII_UX     = 8'h58;
    localparam logic [7:0] ASCII_UZ     = 8'h5A;
    localparam logic [7:0] ASCII_USCORE = 8'h5F;
    localparam logic [7:0] ASCII_LA     = 8'h61;
    localparam logic [7:0] ASCII_LF     = 8'h66;
    localparam logic [7:0] ASCII_LX     = 8'h78;
    localparam logic [7:0] ASCII_LZ     = 8'h7A;

    function automatic cls_e char_class(input logic [7:0] c, input logic uscore_en);
        cls_e cls;
        cls = C_DELIM;
        if (c == ASCII_0)
            cls = C_ZERO;
        else if (c > ASCII_0 && c <= ASCII_9)
            cls = C_DIGIT;
        else if ((c >= ASCII_UA && c <= ASCII_UF) || (c >= ASCII_LA && c <= ASCII_LF))
            cls = C_HEXL;
        else if (c == ASCII_UX || c == ASCII_LX)
            cls = C_XL;
        else if ((c >= ASCII_UA && c <= ASCII_UZ) || (c >= ASCII_LA && c <= ASCII_LZ))
            cls = C_LETTER;
        else if (uscore_en && c == ASCII_USCORE)
            cls = C_LETTER;
        return cls;
    endfunction

endpackage

// File: rtl/token_scanner_if.sv
// Character input and token record output handshakes of the token scanner.
interface token_scanner_if #(
    parameter int LEN_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       char;
    logic             in_last;
    logic             tok_valid;
    logic             tok_ready;
    logic [1:0]       tok_type;
    logic [LEN_W-1:0] tok_len;
    logic             tok_trunc;

    modport master (
        output in_valid, char, in_last, tok_ready,
        input  in_ready, tok_valid, tok_type, tok_len, tok_trunc
    );

    modport slave (
        input  in_valid, char, in_last, tok_ready,
        output in_ready, tok_valid, tok_type, tok_len, tok_trunc
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && q != MAX)
            q <= q + 1'b1;
    end
endmodule

// File: rtl/token_scanner.sv
// Byte-stream lexer: classifies delimiter-separated runs as IDENT/NUMBER/ERROR and
// reports one registered record per token, with saturating per-type token counts.
module token_scanner
    import tok_pkg::*;
#(
    parameter int LEN_W     = 8,
    parameter int CNT_W     = 16,
    parameter bit USCORE_EN = 1'b1,
    parameter bit HEX_EN    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    token_scanner_if.slave   bus,
    output logic [CNT_W-1:0] ident_cnt,
    output logic [CNT_W-1:0] num_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e           state_q, state_d, char_next, st_eff;
    cls_e             cls;
    tok_type_e        emit_type;
    logic             nondelim, is_dig, accept, term, emit;
    logic [LEN_W-1:0] len_q, len_rec;
    logic             trunc_q, trunc_rec;

    logic             vld_p1;
    tok_type_e        type_p1;
    logic [LEN_W-1:0] len_p1;
    logic             trunc_p1;

    assign cls      = char_class(bus.char, USCORE_EN);
    assign nondelim = (cls != C_DELIM);
    assign is_dig   = (cls == C_ZERO) || (cls == C_DIGIT);

    // No bypass: every char, terminating or not, waits while a record is stuck.
    assign bus.in_ready = !vld_p1 || bus.tok_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign term         = !nondelim || bus.in_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        char_next = state_q;
        state_d   = state_q;
        emit_type = TOK_ERROR;
        case (state_q)
            S_IDLE: begin
                if (cls == C_ZERO)
                    char_next = S_ZERO;
                else if (cls == C_DIGIT)
                    char_next = S_NUM;
                else
                    char_next = S_IDENT;
            end
            S_IDENT: char_next = S_IDENT;
            S_NUM:   char_next = is_dig ? S_NUM : S_BAD;
            S_ZERO: begin
                if (is_dig)
                    char_next = S_NUM;
                else if (cls == C_XL && HEX_EN)
                    char_next = S_HXP;
                else
                    char_next = S_BAD;
            end
            S_HXP, S_HEX: char_next = (is_dig || cls == C_HEXL) ? S_HEX : S_BAD;
            default: char_next = S_BAD;
        endcase

        // A closing non-delimiter (in_last) is classified by the state it moves into.
        st_eff = nondelim ? char_next : state_q;
        if (accept)
            state_d = term ? S_IDLE : char_next;
        emit = accept && term && (st_eff != S_IDLE);

        case (st_eff)
            S_IDENT:             emit_type = TOK_IDENT;
            S_NUM, S_ZERO, S_HEX: emit_type = TOK_NUMBER;
            default:             emit_type = TOK_ERROR;
        endcase
    end

    sat_counter #(.W(LEN_W)) u_len (
        .clk   (clk),
        .reset (reset),
        .clr   (accept && term),
        .inc   (accept && nondelim),
        .q     (len_q)
    );

    // The record must include the closing char when in_last lands on a letter/digit.
    assign len_rec   = nondelim ? len_sat_inc(len_q) : len_q;
    assign trunc_rec = trunc_q || (nondelim && (&len_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            trunc_q <= 1'b0;
        else if (accept && term)
            trunc_q <= 1'b0;
        else if (accept && nondelim && (&len_q))
            trunc_q <= 1'b1;
    end

    // ---- stage p1: registered token record, held until the consumer takes it ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            type_p1  <= TOK_IDENT;
            len_p1   <= '0;
            trunc_p1 <= 1'b0;
        end else if (emit) begin
            vld_p1   <= 1'b1;
            type_p1  <= emit_type;
            len_p1   <= len_rec;
            trunc_p1 <= trunc_rec;
        end else if (bus.tok_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign bus.tok_valid = vld_p1;
    assign bus.tok_type  = type_p1;
    assign bus.tok_len   = len_p1;
    assign bus.tok_trunc = trunc_p1;

    sat_counter #(.W(CNT_W)) u_ident_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (emit && emit_type == TOK_IDENT),
        .q     (ident_cnt)
    );

    sat_counter #(.W(CNT_W)) u_num_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (emit && emit_type == TOK_NUMBER),
        .q     (num_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (emit && emit_type == TOK_ERROR),
        .q     (err_cnt)
    );

endmodule

// File: tb/tb_token_scanner.sv
// Directed bench for token_scanner: dut0 uses defaults (USCORE on, HEX off, LEN_W 8),
// dut1 uses HEX on, USCORE off, LEN_W 4 and 2-bit counters.
module tb_token_scanner;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    token_scanner_if #(.LEN_W(8)) if0 ();
    token_scanner_if #(.LEN_W(4)) if1 ();

    logic [15:0] ident0, num0, err0;
    logic [1:0]  ident1, num1, err1;

    token_scanner #(.LEN_W(8), .CNT_W(16), .USCORE_EN(1'b1), .HEX_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0),
        .ident_cnt(ident0), .num_cnt(num0), .err_cnt(err0)
    );

    token_scanner #(.LEN_W(4), .CNT_W(2), .USCORE_EN(1'b0), .HEX_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1),
        .ident_cnt(ident1), .num_cnt(num1), .err_cnt(err1)
    );

    typedef struct packed {
        logic [1:0] ty;
        logic [7:0] len;
        logic       tr;
    } rec_t;

    int   vectors = 0;
    int   miscompares = 0;
    rec_t q0[$];
    rec_t q1[$];
    rec_t exp_q[$];
    int   stall0 = 0;
    int   e_ident0 = 0, e_num0 = 0, e_err0 = 0;

    // Records are logged on the negedge before the posedge that transfers them.
    always @(negedge clk) begin
        rec_t r;
        if (if0.tok_valid && if0.tok_ready) begin
            r.ty = if0.tok_type; r.len = if0.tok_len; r.tr = if0.tok_trunc;
            q0.push_back(r);
        end
        if (if1.tok_valid && if1.tok_ready) begin
            r.ty = if1.tok_type; r.len = {4'b0, if1.tok_len}; r.tr = if1.tok_trunc;
            q1.push_back(r);
        end
        if (if0.in_valid && !if0.in_ready) stall0++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic rec_t mk(int ty, int len, int tr);
        rec_t r;
        r.ty = ty[1:0]; r.len = len[7:0]; r.tr = tr[0];
        return r;
    endfunction

    task automatic drive(int d, logic v, logic [7:0] c, logic last);
        if (d == 0) begin if0.in_valid = v; if0.char = c; if0.in_last = last; end
        else        begin if1.in_valid = v; if1.char = c; if1.in_last = last; end
    endtask

    function automatic logic rdy(int d);
        return (d == 0) ? if0.in_ready : if1.in_ready;
    endfunction

    task automatic send_char(int d, logic [7:0] c, logic last);
        bit acc = 1'b0;
        drive(d, 1'b1, c, last);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy(d)) begin acc = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (!acc) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout dut%0d char=%02h: in_ready stayed 0, required 1", d, c);
        end
    endtask

    task automatic send_str(int d, string s, bit last_on_end);
        for (int i = 0; i < s.len(); i++)
            send_char(d, s[i], last_on_end && (i == s.len() - 1));
        drive(d, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        vectors++;
        if (if0.tok_valid !== 1'b0 || if0.tok_type !== 2'd0 || if0.tok_len !== 8'd0 || if0.tok_trunc !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rec0: valid=%b type=%0d len=%0d trunc=%b, required 0 0 0 0",
                     if0.tok_valid, if0.tok_type, if0.tok_len, if0.tok_trunc);
        end
        vectors++;
        if (if1.tok_valid !== 1'b0 || if1.tok_type !== 2'd0 || if1.tok_len !== 4'd0 || if1.tok_trunc !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rec1: valid=%b type=%0d len=%0d trunc=%b, required 0 0 0 0",
                     if1.tok_valid, if1.tok_type, if1.tok_len, if1.tok_trunc);
        end
        vectors++;
        if (ident0 !== 16'd0 || num0 !== 16'd0 || err0 !== 16'd0 || ident1 !== 2'd0 || num1 !== 2'd0 || err1 !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: %0d %0d %0d %0d %0d %0d, required all 0", ident0, num0, err0, ident1, num1, err1);
        end
        vectors++;
        if (if0.in_ready !== 1'b1 || if1.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: %b %b, required 1 1", if0.in_ready, if1.in_ready);
        end
    endtask

    task automatic test_ident;
        q0.delete(); stall0 = 0;
        send_str(0, "ab12 ", 1'b0); idle(3);
        exp_q.delete(); exp_q.push_back(mk(0, 4, 0));
        e_ident0 += 1;
        vectors++;
        if (q0.size() != exp_q.size()) begin
            miscompares++; $display("FAIL ident_count: %0d records, required %0d", q0.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= q0.size() || q0[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL ident_rec%0d: got %h, required %h", i, (i < q0.size()) ? q0[i] : '0, exp_q[i]);
            end
        end
        vectors++;
        if (stall0 != 0) begin miscompares++; $display("FAIL ident_stall: in_ready low %0d cycles, required 0", stall0); end
        vectors++;
        if (ident0 !== 16'(e_ident0)) begin miscompares++; $display("FAIL ident_cnt: got %0d, required %0d", ident0, e_ident0); end
    endtask

    task automatic test_number_error;
        q0.delete();
        send_str(0, "9a ", 1'b0);
        send_str(0, "007 ", 1'b0);
        send_str(0, "0x1 ", 1'b0);
        idle(3);
        exp_q.delete();
        exp_q.push_back(mk(2, 2, 0)); exp_q.push_back(mk(1, 3, 0)); exp_q.push_back(mk(2, 3, 0));
        e_err0 += 2; e_num0 += 1;
        vectors++;
        if (q0.size() != exp_q.size()) begin
            miscompares++; $display("FAIL numerr_count: %0d records, required %0d", q0.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= q0.size() || q0[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL numerr_rec%0d: got %h, required %h", i, (i < q0.size()) ? q0[i] : '0, exp_q[i]);
            end
        end
        vectors++;
        if (num0 !== 16'(e_num0) || err0 !== 16'(e_err0)) begin
            miscompares++; $display("FAIL numerr_cnt: num=%0d err=%0d, required %0d %0d", num0, err0, e_num0, e_err0);
        end
    endtask

    task automatic test_last_and_delims;
        q0.delete();
        send_str(0, "a b", 1'b1);
        send_str(0, "  \t", 1'b1);
        send_str(0, "_a ", 1'b0);
        idle(3);
        exp_q.delete();
        exp_q.push_back(mk(0, 1, 0)); exp_q.push_back(mk(0, 1, 0)); exp_q.push_back(mk(0, 2, 0));
        e_ident0 += 3;
        vectors++;
        if (q0.size() != exp_q.size()) begin
            miscompares++; $display("FAIL last_count: %0d records, required %0d", q0.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= q0.size() || q0[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL last_rec%0d: got %h, required %h", i, (i < q0.size()) ? q0[i] : '0, exp_q[i]);
            end
        end
        vectors++;
        if (ident0 !== 16'(e_ident0)) begin miscompares++; $display("FAIL last_cnt: got %0d, required %0d", ident0, e_ident0); end
    endtask

    task automatic test_hex_trunc_sat;
        q1.delete();
        send_str(1, "0x1F ", 1'b0);
        send_str(1, "0x ", 1'b0);
        send_str(1, "0xg ", 1'b0);
        send_str(1, "_a ", 1'b0);
        send_str(1, "aaaaaaaaaaaaaaaaaaaa ", 1'b0);
        send_str(1, "a ", 1'b0);
        send_str(1, "b ", 1'b0);
        idle(3);
        exp_q.delete();
        exp_q.push_back(mk(1, 4, 0));  exp_q.push_back(mk(2, 2, 0)); exp_q.push_back(mk(2, 3, 0));
        exp_q.push_back(mk(0, 1, 0));  exp_q.push_back(mk(0, 15, 1)); exp_q.push_back(mk(0, 1, 0));
        exp_q.push_back(mk(0, 1, 0));
        vectors++;
        if (q1.size() != exp_q.size()) begin
            miscompares++; $display("FAIL hex_count: %0d records, required %0d", q1.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= q1.size() || q1[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL hex_rec%0d: got %h, required %h", i, (i < q1.size()) ? q1[i] : '0, exp_q[i]);
            end
        end
        vectors++;
        if (ident1 !== 2'd3 || num1 !== 2'd1 || err1 !== 2'd2) begin
            miscompares++; $display("FAIL hex_cnt_sat: ident=%0d num=%0d err=%0d, required 3 1 2", ident1, num1, err1);
        end
    endtask

    task automatic test_back_to_back;
        q0.delete();
        if0.tok_ready = 1'b0;
        fork
            send_str(0, "x y ", 1'b0);
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (if0.tok_valid) begin seen = 1'b1; break; end
                end
                vectors++;
                if (!seen) begin miscompares++; $display("FAIL bp_first_valid: tok_valid=0, required 1"); end
                for (int k = 0; k < 5; k++) begin
                    vectors++;
                    if (if0.tok_valid !== 1'b1 || if0.tok_type !== 2'd0 || if0.tok_len !== 8'd1 || if0.in_ready !== 1'b0) begin
                        miscompares++;
                        $display("FAIL bp_hold%0d: valid=%b type=%0d len=%0d in_ready=%b, required 1 0 1 0",
                                 k, if0.tok_valid, if0.tok_type, if0.tok_len, if0.in_ready);
                    end
                    @(negedge clk);
                end
                @(posedge clk); #1;
                if0.tok_ready = 1'b1;
            end
        join
        idle(3);
        e_ident0 += 2;
        vectors++;
        if (q0.size() != 2) begin miscompares++; $display("FAIL bp_count: %0d records, required 2", q0.size()); end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (i >= q0.size() || q0[i] !== mk(0, 1, 0)) begin
                miscompares++; $display("FAIL bp_rec%0d: got %h, required %h", i, (i < q0.size()) ? q0[i] : '0, mk(0, 1, 0));
            end
        end
        vectors++;
        if (ident0 !== 16'(e_ident0)) begin miscompares++; $display("FAIL bp_cnt: got %0d, required %0d", ident0, e_ident0); end
    endtask

    task automatic test_reset_mid;
        q0.delete();
        if0.tok_ready = 1'b0;
        send_str(0, "c ", 1'b0);
        vectors++;
        if (if0.tok_valid !== 1'b1) begin miscompares++; $display("FAIL rm_pending: tok_valid=%b, required 1", if0.tok_valid); end
        drive(0, 1'b1, "a", 1'b0);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (if0.tok_valid !== 1'b0 || ident0 !== 16'd0 || num0 !== 16'd0 || err0 !== 16'd0 || ident1 !== 2'd0) begin
            miscompares++;
            $display("FAIL rm_cleared: valid=%b ident=%0d num=%0d err=%0d ident1=%0d, required all 0",
                     if0.tok_valid, ident0, num0, err0, ident1);
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        if0.tok_ready = 1'b1;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        send_str(0, "zz", 1'b0);
        #2 reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        send_str(0, "q ", 1'b0);
        idle(3);
        vectors++;
        if (q0.size() != 1) begin miscompares++; $display("FAIL rm_count: %0d records, required 1", q0.size()); end
        vectors++;
        if (q0.size() < 1 || q0[0] !== mk(0, 1, 0)) begin
            miscompares++; $display("FAIL rm_rec: got %h, required %h", (q0.size() > 0) ? q0[0] : '0, mk(0, 1, 0));
        end
        vectors++;
        if (ident0 !== 16'd1) begin miscompares++; $display("FAIL rm_cnt: got %0d, required 1", ident0); end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        if0.tok_ready = 1'b1;
        if1.tok_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_ident;
        test_number_error;
        test_last_and_delims;
        test_hex_trunc_sat;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
